// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
//   Shared definitions for the data-RAM access path.
//   - mem_state_e : controller state encoding (IDLE, ACCESS, RD_WAIT, RESP, ERR)
//   - MEM_DATA_WIDTH / MEM_ADDR_WIDTH : RAM word and address widths
//   - MEM_MAX_ADDR : highest populated word address
//   - MEM_READ_LATENCY : RAM clock edges from address sampling to valid data
// ---------------------------------------------------------------------------
package mem_pkg;

    localparam int MEM_DATA_WIDTH   = 16;
    localparam int MEM_ADDR_WIDTH   = 10;
    localparam int MEM_MAX_ADDR     = 511;
    localparam int MEM_READ_LATENCY = 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ACCESS  = 3'd1,
        RD_WAIT = 3'd2,
        RESP    = 3'd3,
        ERR     = 3'd4
    } mem_state_e;

endpackage : mem_pkg

// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
//   Initiator-side controller for one port of the dual-port data RAM.
//   Takes single-word load/store requests over a valid/ready handshake,
//   drives registered RAM address/data/write-enable, waits out the RAM read
//   latency and returns a one-cycle response pulse. Requests above MAX_ADDR
//   never touch the RAM and get an error response instead.
//
// Ports
//   clk, reset             : clock (rising edge), synchronous active-high reset
//   req_valid/req_ready    : request handshake, accepted when both are high
//   req_we/addr/wdata      : store flag, word address, store data
//   resp_valid             : one-cycle completion pulse
//   resp_err               : out-of-range address (qualified by resp_valid)
//   resp_rdata             : load data / stored word / 0 on error
//   mem_addr/data/we       : registered RAM port controls
//   mem_q                  : RAM read data
// ---------------------------------------------------------------------------
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH   = MEM_DATA_WIDTH,
    parameter int ADDR_WIDTH   = MEM_ADDR_WIDTH,
    parameter int MAX_ADDR     = MEM_MAX_ADDR,
    parameter int READ_LATENCY = MEM_READ_LATENCY
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic                  resp_err,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_q
);

    // Widened compare so a MAX_ADDR at the top of the address space never
    // truncates into a false error.
    localparam logic [ADDR_WIDTH:0] MAX_ADDR_EXT = (ADDR_WIDTH+1)'(MAX_ADDR);
    localparam logic [1:0]          LAT_LAST     = 2'(READ_LATENCY - 1);

    mem_state_e            state_q, state_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  resp_valid_q, resp_valid_d;
    logic                  resp_err_q, resp_err_d;
    logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
    logic                  mem_we_q, mem_we_d;
    logic                  addr_oob;

    assign addr_oob = {1'b0, req_addr} > MAX_ADDR_EXT;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave it unassigned and infer a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = resp_rdata_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        mem_we_d     = 1'b0;

        case (state_q)
            IDLE: begin
                // req_ready is high in IDLE, so req_valid alone means accept.
                if (req_valid) begin
                    if (addr_oob) begin
                        state_d      = ERR;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                    end else begin
                        // The RAM port registers double as the captured request.
                        state_d    = ACCESS;
                        mem_addr_d = req_addr;
                        mem_data_d = req_wdata;
                        mem_we_d   = req_we;
                    end
                end
            end
            ACCESS: begin
                // mem_we_q holds the captured store flag for this cycle only.
                if (mem_we_q) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = mem_data_q;
                end else begin
                    state_d = RD_WAIT;
                    cnt_d   = '0;
                end
            end
            RD_WAIT: begin
                // RAM sampled mem_addr at the end of ACCESS; data is valid
                // READ_LATENCY edges later, i.e. at the end of the last wait cycle.
                if (cnt_q == LAT_LAST) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = mem_q;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            RESP, ERR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            mem_we_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            mem_we_q     <= mem_we_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign mem_addr   = mem_addr_q;
    assign mem_data   = mem_data_q;
    assign mem_we     = mem_we_q;

endmodule : mem_access_ctrl
